// File: rtl/rf_wb_pkg.sv
// Shared widths, constants and the queue entry type for the register-file writeback queue.
package rf_wb_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WBQ_DEPTH = 4;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_bypass_match.sv
// Combinational youngest-match search over the writeback queue for one operand lookup.
module wbq_bypass_match #(
    parameter int unsigned DEPTH = 4
) (
    input  rf_wb_pkg::wb_entry_t              i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]          i_tail,
    input  logic [rf_wb_pkg::ADDR_W-1:0]      i_addr,
    output logic                              o_hit,
    output logic [rf_wb_pkg::DATA_W-1:0]      o_data
);
    import rf_wb_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              w_match;
    logic [DATA_W-1:0] w_data;
    logic [PTR_W-1:0]  w_idx;

    // Walk oldest to youngest (tail-DEPTH .. tail-1) so the youngest match overwrites.
    always_comb begin
        w_match = 1'b0;
        w_data  = '0;
        w_idx   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PTR_W'(k);
            if (i_entries[w_idx].valid && (i_entries[w_idx].addr == i_addr)) begin
                w_match = 1'b1;
                w_data  = i_entries[w_idx].data;
            end
        end
    end

    assign o_hit  = w_match & (i_addr != REG_ZERO);
    assign o_data = o_hit ? w_data : '0;

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue: accepts load/ALU results, drains one register-file write per
// clock, and offers bypass lookups over entries not yet committed.
module rf_writeback_queue #(
    parameter int unsigned DEPTH  = rf_wb_pkg::WBQ_DEPTH,
    parameter int unsigned ADDR_W = rf_wb_pkg::ADDR_W,
    parameter int unsigned DATA_W = rf_wb_pkg::DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_alu_valid,
    input  logic [ADDR_W-1:0]          i_alu_addr,
    input  logic [DATA_W-1:0]          i_alu_data,
    output logic                       o_alu_ready,
    input  logic                       i_ld_valid,
    input  logic [ADDR_W-1:0]          i_ld_addr,
    input  logic [DATA_W-1:0]          i_ld_data,
    output logic                       o_ld_ready,
    input  logic                       i_rf_hold,
    output logic                       o_rf_we,
    output logic [ADDR_W-1:0]          o_rf_addr,
    output logic [DATA_W-1:0]          o_rf_data,
    input  logic [ADDR_W-1:0]          i_byp1_addr,
    output logic                       o_byp1_hit,
    output logic [DATA_W-1:0]          o_byp1_data,
    input  logic [ADDR_W-1:0]          i_byp2_addr,
    output logic                       o_byp2_hit,
    output logic [DATA_W-1:0]          o_byp2_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    import rf_wb_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_push_addr;
    logic [DATA_W-1:0] w_push_data;
    wb_entry_t         w_head_entry;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Readiness depends only on registered occupancy, never on the same-cycle drain.
    assign o_ld_ready  = i_ld_valid & ~w_full;
    assign o_alu_ready = i_alu_valid & ~w_full & ~i_ld_valid;

    assign w_accept    = o_ld_ready | o_alu_ready;
    assign w_push_addr = i_ld_valid ? i_ld_addr : i_alu_addr;
    assign w_push_data = i_ld_valid ? i_ld_data : i_alu_data;
    assign w_push      = w_accept & (w_push_addr != REG_ZERO);
    assign w_pop       = ~w_empty & ~i_rf_hold;

    assign w_head_entry = r_entries[r_head];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_entries[r_tail].valid <= 1'b1;
                r_entries[r_tail].addr  <= w_push_addr;
                r_entries[r_tail].data  <= w_push_data;
                r_tail                  <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rf_we   = w_pop;
    assign o_rf_addr = w_pop ? w_head_entry.addr : '0;
    assign o_rf_data = w_pop ? w_head_entry.data : '0;

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

    wbq_bypass_match #(
        .DEPTH (DEPTH)
    ) u_byp1 (
        .i_entries (r_entries),
        .i_tail    (r_tail),
        .i_addr    (i_byp1_addr),
        .o_hit     (o_byp1_hit),
        .o_data    (o_byp1_data)
    );

    wbq_bypass_match #(
        .DEPTH (DEPTH)
    ) u_byp2 (
        .i_entries (r_entries),
        .i_tail    (r_tail),
        .i_addr    (i_byp2_addr),
        .o_hit     (o_byp2_hit),
        .o_data    (o_byp2_data)
    );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed self-checking bench for rf_writeback_queue: inputs driven on negedge, checked #1 later.
module tb_rf_writeback_queue;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rf_hold;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  byp1_addr;
    logic        byp1_hit;
    logic [31:0] byp1_data;
    logic [4:0]  byp2_addr;
    logic        byp2_hit;
    logic [31:0] byp2_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks;
    int errors;

    rf_writeback_queue dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_alu_valid (alu_valid),
        .i_alu_addr  (alu_addr),
        .i_alu_data  (alu_data),
        .o_alu_ready (alu_ready),
        .i_ld_valid  (ld_valid),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .o_ld_ready  (ld_ready),
        .i_rf_hold   (rf_hold),
        .o_rf_we     (rf_we),
        .o_rf_addr   (rf_addr),
        .o_rf_data   (rf_data),
        .i_byp1_addr (byp1_addr),
        .o_byp1_hit  (byp1_hit),
        .o_byp1_data (byp1_data),
        .i_byp2_addr (byp2_addr),
        .o_byp2_hit  (byp2_hit),
        .o_byp2_data (byp2_data),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rf_hold = 1'b0;
        idle_inputs();
        byp1_addr = 5'd5;
        byp2_addr = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: we=%b empty=%b count=%0d full=%b, want 0 1 0 0",
                     rf_we, empty, count, full);
        end
        checks++;
        if (byp1_hit !== 1'b0 || byp1_data !== 32'h0 || rf_addr !== 5'd0 || rf_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: hit=%b bdata=%h addr=%0d data=%h, want all 0",
                     byp1_hit, byp1_data, rf_addr, rf_data);
        end
    endtask

    task automatic test_alu_single();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_00AA;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_accept: alu_ready=%b ld_ready=%b we=%b, want 1 0 0",
                     alu_ready, ld_ready, rf_we);
        end
        @(negedge clk);
        idle_inputs();
        byp1_addr = 5'd3;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'hAA || count !== 3'd1) begin
            errors++;
            $display("FAIL alu_drain: we=%b addr=%0d data=%h count=%0d, want 1 3 aa 1",
                     rf_we, rf_addr, rf_data, count);
        end
        checks++;
        if (byp1_hit !== 1'b1 || byp1_data !== 32'hAA) begin
            errors++;
            $display("FAIL byp_draining: hit=%b data=%h, want 1 aa", byp1_hit, byp1_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (empty !== 1'b1 || rf_we !== 1'b0 || rf_addr !== 5'd0 || byp1_hit !== 1'b0) begin
            errors++;
            $display("FAIL alu_after: empty=%b we=%b addr=%0d hit=%b, want 1 0 0 0",
                     empty, rf_we, rf_addr, byp1_hit);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'h11;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h22;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_cycle1: ld_ready=%b alu_ready=%b, want 1 0", ld_ready, alu_ready);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h11) begin
            errors++;
            $display("FAIL prio_cycle2: alu_ready=%b we=%b addr=%0d data=%h, want 1 1 4 11",
                     alu_ready, rf_we, rf_addr, rf_data);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h22 || count !== 3'd1) begin
            errors++;
            $display("FAIL prio_cycle3: we=%b addr=%0d data=%h count=%0d, want 1 5 22 1",
                     rf_we, rf_addr, rf_data, count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (empty !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL prio_empty: empty=%b we=%b, want 1 0", empty, rf_we);
        end
    endtask

    task automatic test_full();
        rf_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_addr = 5'(i); ld_data = 32'(i);
            #1;
            checks++;
            if (ld_ready !== 1'b1 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL full_push%0d: ld_ready=%b we=%b, want 1 0", i, ld_ready, rf_we);
            end
        end
        @(negedge clk);
        ld_addr = 5'd5; ld_data = 32'h5;
        alu_valid = 1'b1; alu_addr = 5'd6;
        #1;
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || ld_ready !== 1'b0 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: full=%b count=%0d ld_ready=%b alu_ready=%b, want 1 4 0 0",
                     full, count, ld_ready, alu_ready);
        end
        @(negedge clk);
        idle_inputs();
        rf_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== 5'(i) || rf_data !== 32'(i)) begin
                errors++;
                $display("FAIL full_drain%0d: we=%b addr=%0d data=%h, want 1 %0d %h",
                         i, rf_we, rf_addr, rf_data, i, i);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (empty !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: empty=%b we=%b, want 1 0", empty, rf_we);
        end
    endtask

    task automatic test_bypass();
        logic [4:0]  exp_addr [4];
        logic [31:0] exp_data [4];
        exp_addr[0] = 5'd7; exp_data[0] = 32'h10;
        exp_addr[1] = 5'd7; exp_data[1] = 32'h20;
        exp_addr[2] = 5'd3; exp_data[2] = 32'h30;
        exp_addr[3] = 5'd9; exp_data[3] = 32'h99;
        rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_addr = exp_addr[i]; alu_data = exp_data[i];
        end
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
        byp1_addr = 5'd7; byp2_addr = 5'd0;
        #1;
        checks++;
        if (byp1_hit !== 1'b1 || byp1_data !== 32'h20 || byp2_hit !== 1'b0 || byp2_data !== 32'h0)
        begin
            errors++;
            $display("FAIL byp_youngest: h1=%b d1=%h h2=%b d2=%h, want 1 20 0 0",
                     byp1_hit, byp1_data, byp2_hit, byp2_data);
        end
        checks++;
        if (alu_ready !== 1'b1 || count !== 3'd3) begin
            errors++;
            $display("FAIL r0_accept: alu_ready=%b count=%0d, want 1 3", alu_ready, count);
        end
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        byp1_addr = 5'd3; byp2_addr = 5'd9;
        #1;
        checks++;
        if (count !== 3'd3 || byp1_hit !== 1'b1 || byp1_data !== 32'h30 || byp2_hit !== 1'b0) begin
            errors++;
            $display("FAIL r0_dropped: count=%0d h1=%b d1=%h h2=%b, want 3 1 30 0",
                     count, byp1_hit, byp1_data, byp2_hit);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || byp2_hit !== 1'b1 || byp2_data !== 32'h99) begin
            errors++;
            $display("FAIL byp_next_cycle: count=%0d full=%b h2=%b d2=%h, want 4 1 1 99",
                     count, full, byp2_hit, byp2_data);
        end
        @(negedge clk);
        rf_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== exp_addr[i] || rf_data !== exp_data[i]) begin
                errors++;
                $display("FAIL byp_drain%0d: we=%b addr=%0d data=%h, want 1 %0d %h",
                         i, rf_we, rf_addr, rf_data, exp_addr[i], exp_data[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (empty !== 1'b1 || byp2_hit !== 1'b0) begin
            errors++;
            $display("FAIL byp_empty: empty=%b h2=%b, want 1 0", empty, byp2_hit);
        end
    endtask

    task automatic test_reset_mid_drain();
        rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_addr = 5'(10 + i); ld_data = 32'hA0 + 32'(i);
        end
        @(negedge clk);
        idle_inputs();
        rf_hold = 1'b0;
        byp1_addr = 5'd11;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd10 || count !== 3'd3) begin
            errors++;
            $display("FAIL mid_drain_start: we=%b addr=%0d count=%0d, want 1 10 3",
                     rf_we, rf_addr, count);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: we=%b addr=%0d count=%0d empty=%b, want 0 0 0 1",
                     rf_we, rf_addr, count, empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rf_we !== 1'b0 || empty !== 1'b1 || byp1_hit !== 1'b0) begin
                errors++;
                $display("FAIL post_reset%0d: we=%b empty=%b hit=%b, want 0 1 0",
                         i, rf_we, empty, byp1_hit);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_single();
        test_priority();
        test_full();
        test_bypass();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
